// File: rtl/mac_pkg.sv
// mac_pkg: helpers shared by the pipelined MAC.
// Contents: the S1 control flags struct, and product-extension and saturation-bound helpers.
// The helpers work on MAX_W-bit vectors; callers size the results down to their own widths.
package mac_pkg;

  localparam int MAX_W = 64;

  // Control flags carried alongside the S1 payload. The payload itself has
  // parameter-dependent widths, so each instantiating module wraps this
  // struct in its own local struct.
  typedef struct packed {
    logic first;
    logic last;
    logic valid;
  } s1_ctl_t;

  // Extends a pw-bit product to MAX_W bits. The extension is by sign when sgn is set,
  // and by zeros otherwise.
  function automatic logic [MAX_W-1:0] ext_prod(input logic [MAX_W-1:0] p,
                                                input int pw, input bit sgn);
    logic [MAX_W-1:0] hi;
    logic [5:0]       msb;
    hi  = ~((MAX_W'(1) << pw) - MAX_W'(1));
    msb = 6'(pw - 1);
    if (sgn && p[msb]) return p | hi;
    return p & ~hi;
  endfunction

  // Largest representable w-bit value (two's-complement when sgn).
  function automatic logic [MAX_W-1:0] sat_max(input int w, input bit sgn);
    logic [MAX_W-1:0] m;
    m = (MAX_W'(1) << w) - MAX_W'(1);
    if (sgn) m = m >> 1;
    return m;
  endfunction

  // Smallest representable w-bit value (bit pattern, zero-extended).
  function automatic logic [MAX_W-1:0] sat_min(input int w, input bit sgn);
    if (sgn) return MAX_W'(1) << (w - 1);
    return '0;
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: ACC_WIDTH adder that either clamps or wraps on overflow.
// Ports: a, b (addends), sum (clamped or wrapped result), ovf (true sum not representable).
// Purely combinational; SIGNED selects two's-complement interpretation.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 1
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 ovf
);

  localparam logic [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'(sat_max(ACC_WIDTH, SIGNED != 0));
  localparam logic [ACC_WIDTH-1:0] MINV = ACC_WIDTH'(sat_min(ACC_WIDTH, SIGNED != 0));

  logic [ACC_WIDTH:0] wide;

  always_comb begin
    if (SIGNED != 0) begin
      wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
      // Same-sign operands whose sum flips sign have overflowed.
      ovf  = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (wide[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      ovf  = wide[ACC_WIDTH];
    end
    sum = wide[ACC_WIDTH-1:0];
    // Signed overflow direction follows the common operand sign. Unsigned overflow is always upward.
    if ((SATURATE != 0) && ovf)
      sum = ((SIGNED != 0) && a[ACC_WIDTH-1]) ? MINV : MAXV;
  end

endmodule

// File: rtl/mac_accum_pipe.sv
// mac_accum_pipe: two-stage pipelined multiply-accumulate with first/last framing.
// Ports: clk/rst; in_valid/in_ready, A, B, C, first and last form the input beat.
// The result side is out_valid/out_ready, out, overflow and out_count. It takes 2 edges from the last beat to out_valid.
module mac_accum_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH_A   = 5,
  parameter int WIDTH_B   = 7,
  parameter int ACC_WIDTH = 16,
  parameter int SIGNED    = 0,
  parameter int SATURATE  = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   A,
  input  logic [WIDTH_B-1:0]   B,
  input  logic [ACC_WIDTH-1:0] C,
  input  logic                 first,
  input  logic                 last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] out_count
);

  localparam int PW = WIDTH_A + WIDTH_B;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (ACC_WIDTH < PW) begin : g_bad_acc_width
    $error("mac_accum_pipe: ACC_WIDTH must be >= WIDTH_A + WIDTH_B");
  end
  if (ACC_WIDTH > MAX_W || PW > MAX_W) begin : g_bad_max_width
    $error("mac_accum_pipe: widths exceed mac_pkg::MAX_W");
  end

  typedef struct packed {
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] c;
    s1_ctl_t              ctl;
  } s1_t;

  s1_t                  s1;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf_st;
  logic [CNT_WIDTH-1:0] cnt;

  // The whole pipe freezes only while a finished result sits unconsumed.
  logic advance;
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Both operands are extended to the full product width first. The low PW bits of
  // that product are then exact for signed and unsigned operands alike.
  logic [PW-1:0] a_x, b_x, prod;
  always_comb begin
    if (SIGNED != 0) begin
      a_x = {{WIDTH_B{A[WIDTH_A-1]}}, A};
      b_x = {{WIDTH_A{B[WIDTH_B-1]}}, B};
    end else begin
      a_x = {{WIDTH_B{1'b0}}, A};
      b_x = {{WIDTH_A{1'b0}}, B};
    end
    prod = a_x * b_x;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (advance) begin
      s1.prod      <= prod;
      s1.c         <= C;
      s1.ctl.first <= first;
      s1.ctl.last  <= last;
      s1.ctl.valid <= in_valid;
    end
  end

  // Stage 2 datapath
  logic [ACC_WIDTH-1:0] base, p_ext, res;
  logic                 ovf, ovf_new;
  logic [CNT_WIDTH-1:0] cnt_new;

  always_comb begin
    base    = s1.ctl.first ? s1.c : acc;
    p_ext   = ACC_WIDTH'(ext_prod(MAX_W'(s1.prod), PW, SIGNED != 0));
    ovf_new = (s1.ctl.first ? 1'b0 : ovf_st) | ovf;
    if (s1.ctl.first)       cnt_new = CNT_WIDTH'(1);
    else if (cnt == CNT_MAX) cnt_new = cnt;
    else                     cnt_new = cnt + CNT_WIDTH'(1);
  end

  mac_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SIGNED    (SIGNED),
    .SATURATE  (SATURATE)
  ) u_add (
    .a   (base),
    .b   (p_ext),
    .sum (res),
    .ovf (ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf_st    <= 1'b0;
      cnt       <= '0;
      out       <= '0;
      overflow  <= 1'b0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (advance) begin
      if (s1.ctl.valid) begin
        acc    <= res;
        ovf_st <= ovf_new;
        cnt    <= cnt_new;
        if (s1.ctl.last) begin
          out       <= res;
          overflow  <= ovf_new;
          out_count <= cnt_new;
        end
      end
      // A pending result is either consumed here or not present at all, so
      // out_valid simply follows whether a new result loads on this edge.
      out_valid <= s1.ctl.valid && s1.ctl.last;
    end
  end

endmodule

// File: tb/tb_mac_accum_pipe.sv
module tb_mac_accum_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, first, last;
  logic [4:0]  in_a;
  logic [6:0]  in_b;
  logic [15:0] in_c;
  logic [11:0] in_c12;
  assign in_c12 = in_c[11:0];

  logic        rdy_def, rdy_sgn, rdy_s12, rdy_w12;
  logic        vld_def, vld_sgn, vld_s12, vld_w12;
  logic        ovf_def, ovf_sgn, ovf_s12, ovf_w12;
  logic [15:0] out_def, out_sgn;
  logic [11:0] out_s12, out_w12;
  logic [7:0]  cnt_def, cnt_sgn, cnt_s12, cnt_w12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_accum_pipe u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_def), .A(in_a), .B(in_b), .C(in_c),
    .first(first), .last(last), .out_valid(vld_def), .out_ready(out_ready), .out(out_def),
    .overflow(ovf_def), .out_count(cnt_def));

  mac_accum_pipe #(.SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_sgn), .A(in_a), .B(in_b), .C(in_c),
    .first(first), .last(last), .out_valid(vld_sgn), .out_ready(out_ready), .out(out_sgn),
    .overflow(ovf_sgn), .out_count(cnt_sgn));

  mac_accum_pipe #(.ACC_WIDTH(12), .SATURATE(1)) u_s12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s12), .A(in_a), .B(in_b), .C(in_c12),
    .first(first), .last(last), .out_valid(vld_s12), .out_ready(out_ready), .out(out_s12),
    .overflow(ovf_s12), .out_count(cnt_s12));

  mac_accum_pipe #(.ACC_WIDTH(12), .SATURATE(0)) u_w12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w12), .A(in_a), .B(in_b), .C(in_c12),
    .first(first), .last(last), .out_valid(vld_w12), .out_ready(out_ready), .out(out_w12),
    .overflow(ovf_w12), .out_count(cnt_w12));

  typedef struct {
    logic [4:0]  a;
    logic [6:0]  b;
    logic [15:0] c;
    logic [15:0] e_def; logic o_def;
    logic [15:0] e_sgn; logic o_sgn;
    logic [11:0] e_s12; logic o_s12;
    logic [11:0] e_w12; logic o_w12;
  } vec_t;

  localparam int NV = 8;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Offer one beat and return just after the edge that accepts it.
  task automatic send(input logic [4:0] a, input logic [6:0] b, input logic [15:0] c,
                      input logic f, input logic l);
    @(negedge clk);
    in_a = a; in_b = b; in_c = c; first = f; last = l; in_valid = 1'b1;
    for (int t = 0; t < 50 && !rdy_def; t++) @(negedge clk);
    checks++;
    if (!rdy_def) begin
      errors++;
      $display("FAIL send_accept: in_ready got 0 expected 1 after 50 cycles");
    end
    @(posedge clk);
  endtask

  // Idle the input and wait (bounded) until a result is presented.
  task automatic wait_out(input string name);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      in_valid = 1'b0;
      seen = vld_def;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1 within 20 cycles", name);
    end
  endtask

  initial begin
    vt[0] = '{5'd13, 7'd23,  16'd1012,   16'd1311,   1'b0, 16'd1311,   1'b0, 12'd1311, 1'b0, 12'd1311, 1'b0};
    vt[1] = '{5'd15, 7'd21,  16'd598,    16'd913,    1'b0, 16'd913,    1'b0, 12'd913,  1'b0, 12'd913,  1'b0};
    vt[2] = '{5'd31, 7'd127, 16'd4000,   16'd7937,   1'b0, 16'd4001,   1'b0, 12'd4095, 1'b1, 12'd3841, 1'b1};
    vt[3] = '{5'd29, 7'd5,   16'd10,     16'd155,    1'b0, 16'hFFFB,   1'b0, 12'd155,  1'b0, 12'd155,  1'b0};
    vt[4] = '{5'd16, 7'd64,  16'd0,      16'd1024,   1'b0, 16'd1024,   1'b0, 12'd1024, 1'b0, 12'd1024, 1'b0};
    vt[5] = '{5'd15, 7'd63,  16'h7FFF,   16'd33712,  1'b0, 16'h7FFF,   1'b1, 12'd4095, 1'b1, 12'd944,  1'b1};
    vt[6] = '{5'd16, 7'd63,  16'h8000,   16'd33776,  1'b0, 16'h8000,   1'b1, 12'd1008, 1'b0, 12'd1008, 1'b0};
    vt[7] = '{5'd1,  7'd1,   16'hFFFF,   16'hFFFF,   1'b1, 16'd0,      1'b0, 12'd4095, 1'b1, 12'd0,    1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_c = '0; first = 1'b0; last = 1'b0;
    #3;
    chk("rst_out", 32'(out_def), 0);
    chk("rst_out_valid", 32'(vld_def), 0);
    chk("rst_overflow", 32'(ovf_def), 0);
    chk("rst_out_count", 32'(cnt_def), 0);
    chk("rst_in_ready", 32'(rdy_def), 1);
    @(negedge clk); rst = 1'b0;

    // Single-shot frames streamed back to back; result k is due two negedges after it is driven.
    for (int i = 0; i < NV + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("v%0d_valid", i-2), 32'(vld_def), 1);
        chk($sformatf("v%0d_def_out", i-2), 32'(out_def), 32'(vt[i-2].e_def));
        chk($sformatf("v%0d_def_ovf", i-2), 32'(ovf_def), 32'(vt[i-2].o_def));
        chk($sformatf("v%0d_def_cnt", i-2), 32'(cnt_def), 1);
        chk($sformatf("v%0d_sgn_out", i-2), 32'(out_sgn), 32'(vt[i-2].e_sgn));
        chk($sformatf("v%0d_sgn_ovf", i-2), 32'(ovf_sgn), 32'(vt[i-2].o_sgn));
        chk($sformatf("v%0d_s12_out", i-2), 32'(out_s12), 32'(vt[i-2].e_s12));
        chk($sformatf("v%0d_s12_ovf", i-2), 32'(ovf_s12), 32'(vt[i-2].o_s12));
        chk($sformatf("v%0d_w12_out", i-2), 32'(out_w12), 32'(vt[i-2].e_w12));
        chk($sformatf("v%0d_w12_ovf", i-2), 32'(ovf_w12), 32'(vt[i-2].o_w12));
      end
      if (i < NV) begin
        in_a = vt[i].a; in_b = vt[i].b; in_c = vt[i].c;
        first = 1'b1; last = 1'b1; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    // Three-beat frame: 12 + 30 + 56
    send(5'd3, 7'd4, 16'd0, 1'b1, 1'b0);
    send(5'd5, 7'd6, 16'd0, 1'b0, 1'b0);
    send(5'd7, 7'd8, 16'd0, 1'b0, 1'b1);
    wait_out("mb");
    chk("mb_out", 32'(out_def), 98);
    chk("mb_cnt", 32'(cnt_def), 3);
    chk("mb_ovf", 32'(ovf_def), 0);

    // Same frame with idle cycles mid-frame
    send(5'd3, 7'd4, 16'd0, 1'b1, 1'b0);
    send(5'd5, 7'd6, 16'd0, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    send(5'd7, 7'd8, 16'd0, 1'b0, 1'b1);
    wait_out("gap");
    chk("gap_out", 32'(out_def), 98);
    chk("gap_cnt", 32'(cnt_def), 3);

    // Backpressure: 2*3+4=10 then 4*5+6=26 then 1*1+0=1 offered while stalled
    @(negedge clk); out_ready = 1'b0;
    send(5'd2, 7'd3, 16'd4, 1'b1, 1'b1);
    send(5'd4, 7'd5, 16'd6, 1'b1, 1'b1);
    @(negedge clk);
    in_a = 5'd1; in_b = 7'd1; in_c = 16'd0; first = 1'b1; last = 1'b1; in_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      chk($sformatf("bp%0d_in_ready", s), 32'(rdy_def), 0);
      chk($sformatf("bp%0d_valid", s), 32'(vld_def), 1);
      chk($sformatf("bp%0d_out", s), 32'(out_def), 10);
      chk($sformatf("bp%0d_cnt", s), 32'(cnt_def), 1);
    end
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    chk("bp_next_valid", 32'(vld_def), 1);
    chk("bp_next_out", 32'(out_def), 26);
    @(negedge clk);
    chk("bp_third_valid", 32'(vld_def), 1);
    chk("bp_third_out", 32'(out_def), 1);
    @(negedge clk);
    chk("bp_drained", 32'(vld_def), 0);

    // Saturated value is the base for the next beat; overflow stays sticky
    send(5'd31, 7'd127, 16'd4000, 1'b1, 1'b0);
    send(5'd1, 7'd1, 16'd0, 1'b0, 1'b1);
    wait_out("sticky");
    chk("sticky_s12_out", 32'(out_s12), 4095);
    chk("sticky_s12_ovf", 32'(ovf_s12), 1);
    chk("sticky_s12_cnt", 32'(cnt_s12), 2);
    chk("sticky_w12_out", 32'(out_w12), 3842);
    chk("sticky_w12_ovf", 32'(ovf_w12), 1);
    chk("sticky_def_out", 32'(out_def), 7938);
    send(5'd1, 7'd1, 16'd0, 1'b1, 1'b1);
    wait_out("clear");
    chk("clear_s12_out", 32'(out_s12), 1);
    chk("clear_s12_ovf", 32'(ovf_s12), 0);

    // Beat counter saturates at 255 over a 301-beat frame
    send(5'd1, 7'd1, 16'd0, 1'b1, 1'b0);
    for (int k = 0; k < 299; k++) send(5'd1, 7'd1, 16'd0, 1'b0, 1'b0);
    send(5'd1, 7'd1, 16'd0, 1'b0, 1'b1);
    wait_out("cntsat");
    chk("cntsat_out", 32'(out_def), 301);
    chk("cntsat_cnt", 32'(cnt_def), 255);

    // Reset mid-frame discards the partial accumulation
    send(5'd3, 7'd4, 16'd0, 1'b1, 1'b0);
    send(5'd5, 7'd6, 16'd0, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mrst_out", 32'(out_def), 0);
    chk("mrst_valid", 32'(vld_def), 0);
    chk("mrst_cnt", 32'(cnt_def), 0);
    chk("mrst_ovf", 32'(ovf_def), 0);
    @(negedge clk); rst = 1'b0;
    send(5'd2, 7'd3, 16'd99, 1'b0, 1'b1);
    wait_out("nofirst");
    chk("nofirst_out", 32'(out_def), 6);
    chk("nofirst_cnt", 32'(cnt_def), 1);
    send(5'd2, 7'd2, 16'd1, 1'b1, 1'b1);
    wait_out("post_rst");
    chk("post_rst_out", 32'(out_def), 5);
    chk("post_rst_cnt", 32'(cnt_def), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
